// File: rtl/arcade_layer_mixer.sv
// arcade_layer_mixer
//   Video layer mixer for monochrome-era arcade cores. Each 1-bit layer picks an
//   RGB colour from a two-bank writable palette; active layers are summed with
//   per-component saturation, optionally inverted frame-wide, blanked, and
//   delivered with syncs/blanks delayed to match the two-stage RGB pipeline.
//
// Ports
//   clk_sys, reset          clock, synchronous active-high reset
//   ce_pix                  pixel enable (pipeline and frame logic)
//   layer_in[LAYERS]        layer-active bits
//   inv_req_in              inversion request for the next frame
//   hs_in/vs_in/hb_in/vb_in syncs and blanks from the core
//   color_mode              bank select, latched on vsync rise
//   pal_we/pal_bank/pal_addr/pal_din  palette write port ({R,G,B}), ignores ce_pix
//   r_out/g_out/b_out       mixed colour
//   hs_out/vs_out/hb_out/vb_out  delayed syncs/blanks
//   inv_active              inversion currently applied
module arcade_layer_mixer #(
  parameter int unsigned LAYERS      = 4,
  parameter int unsigned CW          = 4,
  parameter int unsigned HOLD_FRAMES = 1
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       ce_pix,
  input  logic [LAYERS-1:0]          layer_in,
  input  logic                       inv_req_in,
  input  logic                       hs_in,
  input  logic                       vs_in,
  input  logic                       hb_in,
  input  logic                       vb_in,
  input  logic                       color_mode,
  input  logic                       pal_we,
  input  logic                       pal_bank,
  input  logic [$clog2(LAYERS)-1:0]  pal_addr,
  input  logic [3*CW-1:0]            pal_din,
  output logic [CW-1:0]              r_out,
  output logic [CW-1:0]              g_out,
  output logic [CW-1:0]              b_out,
  output logic                       hs_out,
  output logic                       vs_out,
  output logic                       hb_out,
  output logic                       vb_out,
  output logic                       inv_active
);

  localparam int unsigned AW  = $clog2(LAYERS);
  localparam int unsigned SW  = CW + AW + 1;
  localparam int unsigned HCW = $clog2(HOLD_FRAMES) + 1;

  localparam logic [CW-1:0]   CompRst  = CW'((2 ** (CW - 1)) - 1);
  localparam logic [CW-1:0]   CompMax  = '1;
  localparam logic [3*CW-1:0] PalRst   = {3{CompRst}};
  localparam logic [HCW-1:0]  HoldInit = HCW'(HOLD_FRAMES - 1);

  // Palette
  logic [3*CW-1:0] pal_q [2][LAYERS];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < int'(LAYERS); i++) begin
          pal_q[b][i] <= PalRst;
        end
      end
    end else if (pal_we && (32'(pal_addr) < LAYERS)) begin
      pal_q[pal_bank][pal_addr] <= pal_din;
    end
  end

  // Frame logic state
  logic           vs_d_q, vs_d_d;
  logic           cur_inv_q, cur_inv_d;
  logic           inv_q, inv_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic           bank_sel_q, bank_sel_d;
  logic           vs_rise;

  always_comb begin
    vs_d_d     = vs_d_q;
    cur_inv_d  = cur_inv_q;
    inv_d      = inv_q;
    hold_d     = hold_q;
    bank_sel_d = bank_sel_q;
    vs_rise    = vs_in & ~vs_d_q;
    if (ce_pix) begin
      vs_d_d = vs_in;
      if (!vs_rise) begin
        cur_inv_d = cur_inv_q | inv_req_in;
      end else begin
        bank_sel_d = color_mode;
        // A request on the edge pixel belongs to the frame that is starting.
        cur_inv_d  = inv_req_in;
        if (cur_inv_q) begin
          inv_d  = 1'b1;
          hold_d = HoldInit;
        end else if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
          inv_d  = 1'b1;
        end else begin
          inv_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vs_d_q     <= 1'b0;
      cur_inv_q  <= 1'b0;
      inv_q      <= 1'b0;
      hold_q     <= '0;
      bank_sel_q <= 1'b0;
    end else begin
      vs_d_q     <= vs_d_d;
      cur_inv_q  <= cur_inv_d;
      inv_q      <= inv_d;
      hold_q     <= hold_d;
      bank_sel_q <= bank_sel_d;
    end
  end

  // Stage 1: per-layer colour lookup plus syncs/blanks
  logic [3*CW-1:0] col_s1_q [LAYERS];
  logic [3*CW-1:0] col_s1_d [LAYERS];
  logic [3:0]      sync_s1_q;  // {hs, vs, hb, vb}

  always_comb begin
    for (int i = 0; i < int'(LAYERS); i++) begin
      col_s1_d[i] = layer_in[i] ? pal_q[bank_sel_q][i] : '0;
    end
  end

  // Stage 2: saturating sum, inversion, blanking
  logic [SW-1:0]   sum_c [3];
  logic [3*CW-1:0] rgb_s2_d;
  logic [3*CW-1:0] rgb_s2_q;
  logic [3:0]      sync_s2_q;
  logic            blank_s1;

  always_comb begin
    blank_s1 = sync_s1_q[1] | sync_s1_q[0];
    rgb_s2_d = '0;
    for (int c = 0; c < 3; c++) begin
      sum_c[c] = '0;
      for (int i = 0; i < int'(LAYERS); i++) begin
        sum_c[c] = sum_c[c] + SW'(col_s1_q[i][c*CW +: CW]);
      end
      rgb_s2_d[c*CW +: CW] = (sum_c[c] > SW'(CompMax)) ? CompMax : sum_c[c][CW-1:0];
      rgb_s2_d[c*CW +: CW] = rgb_s2_d[c*CW +: CW] ^ {CW{inv_q}};
      if (blank_s1) begin
        rgb_s2_d[c*CW +: CW] = '0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < int'(LAYERS); i++) begin
        col_s1_q[i] <= '0;
      end
      sync_s1_q <= '0;
      rgb_s2_q  <= '0;
      sync_s2_q <= '0;
    end else if (ce_pix) begin
      for (int i = 0; i < int'(LAYERS); i++) begin
        col_s1_q[i] <= col_s1_d[i];
      end
      sync_s1_q <= {hs_in, vs_in, hb_in, vb_in};
      rgb_s2_q  <= rgb_s2_d;
      sync_s2_q <= sync_s1_q;
    end
  end

  assign r_out      = rgb_s2_q[3*CW-1 -: CW];
  assign g_out      = rgb_s2_q[2*CW-1 -: CW];
  assign b_out      = rgb_s2_q[CW-1:0];
  assign hs_out     = sync_s2_q[3];
  assign vs_out     = sync_s2_q[2];
  assign hb_out     = sync_s2_q[1];
  assign vb_out     = sync_s2_q[0];
  assign inv_active = inv_q;

endmodule

// File: tb/tb_arcade_layer_mixer.sv
// Directed bench for arcade_layer_mixer (LAYERS=4, CW=4, HOLD_FRAMES=3).
module tb_arcade_layer_mixer;

  logic        clk_sys = 1'b0;
  logic        reset, ce_pix, inv_req_in;
  logic [3:0]  layer_in;
  logic        hs_in, vs_in, hb_in, vb_in, color_mode;
  logic        pal_we, pal_bank;
  logic [1:0]  pal_addr;
  logic [11:0] pal_din;
  logic [3:0]  r_out, g_out, b_out;
  logic        hs_out, vs_out, hb_out, vb_out, inv_active;

  logic [11:0] rgb;
  logic [3:0]  syncs;
  assign rgb   = {r_out, g_out, b_out};
  assign syncs = {hs_out, vs_out, hb_out, vb_out};

  int tests  = 0;
  int failed = 0;

  arcade_layer_mixer #(
    .LAYERS      (4),
    .CW          (4),
    .HOLD_FRAMES (3)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce_pix     (ce_pix),
    .layer_in   (layer_in),
    .inv_req_in (inv_req_in),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .hb_in      (hb_in),
    .vb_in      (vb_in),
    .color_mode (color_mode),
    .pal_we     (pal_we),
    .pal_bank   (pal_bank),
    .pal_addr   (pal_addr),
    .pal_din    (pal_din),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out),
    .hs_out     (hs_out),
    .vs_out     (vs_out),
    .hb_out     (hb_out),
    .vb_out     (vb_out),
    .inv_active (inv_active)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pal_write(input logic bank, input logic [1:0] addr, input logic [11:0] din);
    pal_we   = 1'b1;
    pal_bank = bank;
    pal_addr = addr;
    pal_din  = din;
    tick();
    pal_we   = 1'b0;
  endtask

  // One vsync low pixel followed by the rising-edge pixel.
  task automatic frame();
    vs_in = 1'b0;
    tick();
    vs_in = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ce_pix = 1'b1; inv_req_in = 1'b0; layer_in = 4'b0000;
    hs_in = 1'b0; vs_in = 1'b0; hb_in = 1'b0; vb_in = 1'b0; color_mode = 1'b0;
    pal_we = 1'b0; pal_bank = 1'b0; pal_addr = 2'd0; pal_din = 12'h000;

    // 1. Reset state and default palette with two-cycle latency
    tick(); tick();
    check("rst_rgb", 16'(rgb), 16'h000);
    check("rst_syncs", 16'(syncs), 16'h0);
    check("rst_inv", 16'(inv_active), 16'h0);
    reset = 1'b0;
    layer_in = 4'b0001; hs_in = 1'b1;
    tick();
    check("lat1_rgb", 16'(rgb), 16'h000);
    check("lat1_hs", 16'(hs_out), 16'h0);
    tick();
    check("default_l0", 16'(rgb), 16'h777);
    check("lat2_hs", 16'(hs_out), 16'h1);
    hs_in = 1'b0;

    // 2. Palette writes and saturating mix
    pal_write(1'b0, 2'd0, 12'h777);
    pal_write(1'b0, 2'd1, 12'h0FF);
    pal_write(1'b0, 2'd2, 12'hFF0);
    pal_write(1'b1, 2'd1, 12'h359);
    layer_in = 4'b0111; tick(); tick();
    check("mix_sat", 16'(rgb), 16'hFFF);
    layer_in = 4'b0010; tick(); tick();
    check("mix_l1", 16'(rgb), 16'h0FF);
    layer_in = 4'b0001; tick(); tick();
    check("mix_l0", 16'(rgb), 16'h777);
    // Write on the same edge that stage 1 reads: old value goes through first.
    pal_write(1'b0, 2'd0, 12'h123);
    tick();
    check("rw_old", 16'(rgb), 16'h777);
    tick();
    check("rw_new", 16'(rgb), 16'h123);

    // 3. Inversion request, apply on vsync rise, hold for 3 frames
    layer_in = 4'b0000; tick(); tick();
    check("blank_layers", 16'(rgb), 16'h000);
    inv_req_in = 1'b1; tick(); inv_req_in = 1'b0;
    tick(); tick();
    check("inv_same_frame_rgb", 16'(rgb), 16'h000);
    check("inv_same_frame_flag", 16'(inv_active), 16'h0);
    vs_in = 1'b1; tick();
    check("inv_applied", 16'(inv_active), 16'h1);
    check("inv_rise_rgb", 16'(rgb), 16'h000);
    tick();
    check("inv_rgb", 16'(rgb), 16'hFFF);
    check("vs_delay", 16'(vs_out), 16'h1);
    frame();
    check("hold_f2", 16'(inv_active), 16'h1);
    frame();
    check("hold_f3", 16'(inv_active), 16'h1);
    frame();
    check("hold_end", 16'(inv_active), 16'h0);
    tick();
    check("hold_end_rgb", 16'(rgb), 16'h000);

    // 4. Bank switch only at vsync rise; blanking overrides inversion
    layer_in = 4'b0010; tick(); tick();
    check("bank0_l1", 16'(rgb), 16'h0FF);
    color_mode = 1'b1; tick(); tick();
    check("cm_midframe", 16'(rgb), 16'h0FF);
    frame();
    tick();
    check("cm_s1_old", 16'(rgb), 16'h0FF);
    tick();
    check("cm_bank1", 16'(rgb), 16'h359);
    inv_req_in = 1'b1; tick(); inv_req_in = 1'b0;
    frame();
    check("inv2_applied", 16'(inv_active), 16'h1);
    tick(); tick();
    check("inv_bank1", 16'(rgb), 16'hCA6);
    hb_in = 1'b1; tick(); tick();
    check("blank_inv_rgb", 16'(rgb), 16'h000);
    check("blank_inv_hb", 16'(hb_out), 16'h1);
    hb_in = 1'b0; tick(); tick();
    check("unblank_inv", 16'(rgb), 16'hCA6);

    // 5. Pixel-enable gating
    ce_pix = 1'b0;
    for (int i = 0; i < 10; i++) begin
      layer_in = 4'(i);
      hb_in    = i[0];
      hs_in    = ~i[0];
      tick();
    end
    check("frozen_rgb", 16'(rgb), 16'hCA6);
    check("frozen_syncs", 16'(syncs), 16'h4);
    check("frozen_inv", 16'(inv_active), 16'h1);
    hb_in = 1'b0; hs_in = 1'b0; layer_in = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      ce_pix = (k % 4 == 3);
      tick();
      if (k == 6) check("gate_7clk", 16'(rgb), 16'hCA6);
      if (k == 7) check("gate_8clk", 16'(rgb), 16'hFFF);
    end
    ce_pix = 1'b1;

    // 6. Reset while inverted mid-frame
    check("pre_rst_inv", 16'(inv_active), 16'h1);
    reset = 1'b1; vs_in = 1'b0; color_mode = 1'b1; layer_in = 4'b0010;
    tick();
    check("rst2_inv", 16'(inv_active), 16'h0);
    check("rst2_rgb", 16'(rgb), 16'h000);
    check("rst2_syncs", 16'(syncs), 16'h0);
    reset = 1'b0;
    tick(); tick();
    check("rst2_pal_default", 16'(rgb), 16'h777);
    check("rst2_inv_after", 16'(inv_active), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
